iobank0_ctrl: RTL and testbench
===============================

Name: iobank0_ctrl

Overview:
Register-mapped controller for the 20-pad tristate bank. It owns the pad_o / pad_oe / pad_i vectors of the bank. Per pad, it selects between software GPIO and one on-chip peripheral function. It synchronises pad inputs, detects edges and raises a level interrupt. It sits between the SoC peripheral bus and the bank's tristate drivers.

Parameters:
NPADS, 20, number of pads controlled (1..32)
SYNC_STAGES, 2, input synchroniser depth (>=2)

Ports:
clk  input  1  system clock; all logic rising-edge
resetn  input  1  asynchronous active-low reset
bus_req  input  1  register access request, one-cycle pulse or held
bus_we  input  1  1=write, 0=read
bus_addr  input  4  word address
bus_wdata  input  32  write data
bus_rdata  output  32  read data, valid when bus_ready=1
bus_ready  output  1  access complete
periph_o  input  NPADS  peripheral output value per pad
periph_oe  input  NPADS  peripheral output enable per pad
periph_i  output  NPADS  synchronised pad input to peripherals
pad_i  input  NPADS  raw pad input from bank
pad_o  output  NPADS  pad output value to bank
pad_oe  output  NPADS  pad output enable to bank
irq  output  1  level interrupt, OR of (IRQ_STATUS)

Behaviour:
- Reset: all registers 0; bus_ready=0, bus_rdata=0; pad_o=0, pad_oe=0 (all pads Hi-Z); sync chain 0; irq=0.
- Register map (word address, bits [NPADS-1:0]; upper bits read 0, writes ignored):
  - 0x0 OUT rw.
  - 0x1 OE rw.
  - 0x2 IN ro: synchronised input.
  - 0x3 FSEL rw: 1 = peripheral owns the pad.
  - 0x4 RISE_EN rw.
  - 0x5 FALL_EN rw.
  - 0x6 IRQ_STATUS rw1c.
  - 0x7 OUT_SET wo: OUT |= wdata; reads 0.
  - 0x8 OUT_CLR wo: OUT &= ~wdata; reads 0.
  - 0x9-0xF: reads 0, writes ignored, still acknowledged.
- Bus FSM, states IDLE and ACK:
  - IDLE & bus_req -> ACK. Writes take effect at this edge. Reads capture bus_rdata at this edge.
  - In ACK, bus_ready=1 for exactly one cycle, then -> IDLE.
  - bus_req still high in ACK is ignored; a held request is re-accepted in the following IDLE cycle. Minimum spacing is therefore 2 cycles per access.
  - bus_rdata holds its value until the next read; writes do not change it.
- Output mux, combinational from registers, per pad:
  - FSEL=1: pad_o=periph_o, pad_oe=periph_oe.
  - FSEL=0: pad_o=OUT, pad_oe=OE.
  - A register write is visible on the pads the cycle after the accepting edge, i.e. the cycle bus_ready=1.
- Input synchroniser:
  - pad_i passes through a SYNC_STAGES flop chain; the last stage is sync_in.
  - IN and periph_i = sync_in, regardless of FSEL.
  - A pad_i change settles in sync_in after SYNC_STAGES edges.
- Edge detect:
  - One extra flop holds the previous sync_in.
  - rise = sync_in & ~prev; fall = ~sync_in & prev.
  - IRQ_STATUS bit sets when (rise & RISE_EN) | (fall & FALL_EN).
  - Edges on pads with disabled enables are not recorded.
  - Enabling RISE_EN does not retroactively flag an existing high level.
- Simultaneous events:
  - A W1C to IRQ_STATUS in the same cycle as a new edge on the same bit: set wins, bit stays 1.
  - OUT_SET and OUT_CLR cannot coincide because the bus accepts one access at a time.
- irq is registered: it asserts the cycle after a status bit sets and deasserts the cycle after the last bit clears.
- Asynchronous reset mid-access aborts the access; no partial write is retained.

Decomposition:
- Shared package/header holds register word-address constants (ADDR_OUT..ADDR_OUT_CLR) and the FSM state encoding.
- One sub-module: iobank0_sync. It is a parameterised SYNC_STAGES-deep synchroniser plus previous-value flop, and outputs sync_in, rise and fall vectors.
- The top level holds the bus FSM, the registers and the mux.

Test Plan:
- Reset with pad_i=0xFFFFF:
  - during reset: pad_oe=0, pad_o=0, irq=0;
  - after release: read IN returns 0x000FFFFF once SYNC_STAGES+1 cycles have passed.
- Write OE=0x0000F and OUT=0x00005:
  - pad_oe=0x0000F and pad_o=0x00005 in the bus_ready cycle;
  - then OUT_SET 0x2 gives pad_o=0x00007;
  - then OUT_CLR 0x1 gives pad_o=0x00006.
- FSEL=0x00100 with periph_o[8]=1, periph_oe[8]=1 and OUT[8]=0: pad_o[8]=1 and pad_oe[8]=1; clearing FSEL returns pad 8 to OUT/OE=0.
- RISE_EN=0x1, toggle pad_i[0] 0->1:
  - IRQ_STATUS=0x1 and irq=1 within SYNC_STAGES+2 cycles;
  - a 0->1->0 pulse on pad_i[1] (bit disabled) does not set status;
  - W1C 0x1 clears irq the next cycle.
- W1C of bit 0 in the same cycle as a new rising edge on pad 0 -> IRQ_STATUS[0] remains 1 and irq stays high.
- Read of address 0xA -> bus_ready after 1 cycle, rdata=0. Back-to-back held bus_req -> bus_ready pulses every 2nd cycle. resetn low during ACK -> bus_ready=0 immediately and registers return to 0.

Source files
------------

// File: rtl/iobank0_pkg.sv
// Shared definitions for the iobank0 pad-bank controller: register word
// addresses and bus FSM state encoding.
package iobank0_pkg;

    localparam int unsigned BusAw = 4;
    localparam int unsigned BusDw = 32;

    localparam logic [3:0] ADDR_OUT        = 4'h0;
    localparam logic [3:0] ADDR_OE         = 4'h1;
    localparam logic [3:0] ADDR_IN         = 4'h2;
    localparam logic [3:0] ADDR_FSEL       = 4'h3;
    localparam logic [3:0] ADDR_RISE_EN    = 4'h4;
    localparam logic [3:0] ADDR_FALL_EN    = 4'h5;
    localparam logic [3:0] ADDR_IRQ_STATUS = 4'h6;
    localparam logic [3:0] ADDR_OUT_SET    = 4'h7;
    localparam logic [3:0] ADDR_OUT_CLR    = 4'h8;

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StAck  = 1'b1;

endpackage

// File: rtl/iobank0_if.sv
// Register bus between the SoC peripheral bus and the iobank0 controller.
interface iobank0_if;
    import iobank0_pkg::*;

    logic             req;
    logic             we;
    logic [BusAw-1:0] addr;
    logic [BusDw-1:0] wdata;
    logic [BusDw-1:0] rdata;
    logic             ready;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ready
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ready
    );

endinterface

// File: rtl/iobank0_sync.sv
// Pad input synchroniser chain plus a previous-value flop for edge detection.
module iobank0_sync #(
    parameter int unsigned NPADS       = 20,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [NPADS-1:0] pad_i,
    output logic [NPADS-1:0] sync_o,
    output logic [NPADS-1:0] rise_o,
    output logic [NPADS-1:0] fall_o
);

    // Index 0 is the first stage; the top index feeds the rest of the design.
    logic [SYNC_STAGES-1:0][NPADS-1:0] sync_q, sync_d;
    logic [NPADS-1:0]                  prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pad_i};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_o & ~prev_q;
    assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/iobank0_ctrl.sv
// Register-mapped controller for a tristate pad bank: GPIO/peripheral mux,
// synchronised inputs with edge capture, and a level interrupt.
module iobank0_ctrl
    import iobank0_pkg::*;
#(
    parameter int unsigned NPADS       = 20,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    iobank0_if.slave         bus,
    input  logic [NPADS-1:0] periph_o,
    input  logic [NPADS-1:0] periph_oe,
    output logic [NPADS-1:0] periph_i,
    input  logic [NPADS-1:0] pad_i,
    output logic [NPADS-1:0] pad_o,
    output logic [NPADS-1:0] pad_oe,
    output logic             irq
);

    logic [0:0]       state_q, state_d;
    logic [NPADS-1:0] out_q, out_d;
    logic [NPADS-1:0] oe_q, oe_d;
    logic [NPADS-1:0] fsel_q, fsel_d;
    logic [NPADS-1:0] rise_en_q, rise_en_d;
    logic [NPADS-1:0] fall_en_q, fall_en_d;
    logic [NPADS-1:0] irq_status_q, irq_status_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             irq_q, irq_d;

    logic [NPADS-1:0] sync_in, rise, fall, wdata;
    logic [31:0]      rd_val;
    logic             accept;
    logic             unused_wdata;

    iobank0_sync #(
        .NPADS       (NPADS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk),
        .rst_ni (resetn),
        .pad_i  (pad_i),
        .sync_o (sync_in),
        .rise_o (rise),
        .fall_o (fall)
    );

    // A request is only taken in IDLE, so accesses are at least two cycles apart.
    assign accept       = (state_q == StIdle) && bus.req;
    assign wdata        = bus.wdata[NPADS-1:0];
    assign unused_wdata = ^bus.wdata;

    always_comb begin
        rd_val = '0;
        case (bus.addr)
            ADDR_OUT:        rd_val[NPADS-1:0] = out_q;
            ADDR_OE:         rd_val[NPADS-1:0] = oe_q;
            ADDR_IN:         rd_val[NPADS-1:0] = sync_in;
            ADDR_FSEL:       rd_val[NPADS-1:0] = fsel_q;
            ADDR_RISE_EN:    rd_val[NPADS-1:0] = rise_en_q;
            ADDR_FALL_EN:    rd_val[NPADS-1:0] = fall_en_q;
            ADDR_IRQ_STATUS: rd_val[NPADS-1:0] = irq_status_q;
            default:         rd_val = '0;
        endcase
    end

    always_comb begin
        state_d      = accept ? StAck : StIdle;
        out_d        = out_q;
        oe_d         = oe_q;
        fsel_d       = fsel_q;
        rise_en_d    = rise_en_q;
        fall_en_d    = fall_en_q;
        irq_status_d = irq_status_q;
        rdata_d      = rdata_q;

        if (accept && !bus.we) begin
            rdata_d = rd_val;
        end

        if (accept && bus.we) begin
            case (bus.addr)
                ADDR_OUT:        out_d        = wdata;
                ADDR_OE:         oe_d         = wdata;
                ADDR_FSEL:       fsel_d       = wdata;
                ADDR_RISE_EN:    rise_en_d    = wdata;
                ADDR_FALL_EN:    fall_en_d    = wdata;
                ADDR_IRQ_STATUS: irq_status_d = irq_status_q & ~wdata;
                ADDR_OUT_SET:    out_d        = out_q | wdata;
                ADDR_OUT_CLR:    out_d        = out_q & ~wdata;
                default:         ;
            endcase
        end

        // New edges are OR-ed in after the W1C so a coincident set wins.
        irq_status_d = irq_status_d | (rise & rise_en_q) | (fall & fall_en_q);
        irq_d        = |irq_status_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            out_q        <= '0;
            oe_q         <= '0;
            fsel_q       <= '0;
            rise_en_q    <= '0;
            fall_en_q    <= '0;
            irq_status_q <= '0;
            rdata_q      <= '0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_q        <= out_d;
            oe_q         <= oe_d;
            fsel_q       <= fsel_d;
            rise_en_q    <= rise_en_d;
            fall_en_q    <= fall_en_d;
            irq_status_q <= irq_status_d;
            rdata_q      <= rdata_d;
            irq_q        <= irq_d;
        end
    end

    assign bus.ready = (state_q == StAck);
    assign bus.rdata = rdata_q;
    assign pad_o     = (fsel_q & periph_o) | (~fsel_q & out_q);
    assign pad_oe    = (fsel_q & periph_oe) | (~fsel_q & oe_q);
    assign periph_i  = sync_in;
    assign irq       = irq_q;

endmodule

// File: tb/tb_iobank0_ctrl.sv
// Self-checking bench for iobank0_ctrl: vector table, directed corner cases,
// then randomized traffic against a register-level reference model.
module tb_iobank0_ctrl;
    import iobank0_pkg::*;

    localparam int unsigned NP = 20;
    localparam int unsigned SS = 2;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic [NP-1:0] periph_o = '0, periph_oe = '0, pad_i = '0;
    logic [NP-1:0] periph_i, pad_o, pad_oe;
    logic          irq;

    int checks = 0;
    int errors = 0;

    iobank0_if bus_if ();

    iobank0_ctrl #(
        .NPADS       (NP),
        .SYNC_STAGES (SS)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus_if),
        .periph_o  (periph_o),
        .periph_oe (periph_oe),
        .periph_i  (periph_i),
        .pad_i     (pad_i),
        .pad_o     (pad_o),
        .pad_oe    (pad_oe),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [19:0] po;
        logic [19:0] poe;
    } vec_t;

    vec_t vecs [14];

    // Reference model state: register contents and the settled pad level.
    logic [NP-1:0] m_out, m_oe, m_fsel, m_ren, m_fen, m_st, m_pad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One access; returns at the negedge where bus_ready is seen.
    task automatic bus_xfer(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                            output logic [31:0] rd);
        int  n;
        logic ok;
        @(negedge clk);
        bus_if.req   = 1'b1;
        bus_if.we    = we;
        bus_if.addr  = addr;
        bus_if.wdata = wd;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 4) begin
            @(negedge clk);
            n++;
            if (bus_if.ready === 1'b1) ok = 1'b1;
        end
        bus_if.req = 1'b0;
        rd = bus_if.rdata;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bus_ready timeout addr 0x%0h: got 0 expected 1", addr);
        end
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] wd);
        logic [31:0] rd;
        bus_xfer(1'b1, addr, wd, rd);
    endtask

    task automatic rd_chk(input string name, input logic [3:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        bus_xfer(1'b0, addr, 32'h0, rd);
        check(name, rd, exp);
    endtask

    function automatic logic [31:0] m_read(input logic [3:0] a);
        logic [31:0] v;
        v = '0;
        if (a == ADDR_OUT)             v[NP-1:0] = m_out;
        else if (a == ADDR_OE)         v[NP-1:0] = m_oe;
        else if (a == ADDR_IN)         v[NP-1:0] = m_pad;
        else if (a == ADDR_FSEL)       v[NP-1:0] = m_fsel;
        else if (a == ADDR_RISE_EN)    v[NP-1:0] = m_ren;
        else if (a == ADDR_FALL_EN)    v[NP-1:0] = m_fen;
        else if (a == ADDR_IRQ_STATUS) v[NP-1:0] = m_st;
        return v;
    endfunction

    function automatic logic [NP-1:0] m_pick(input logic [NP-1:0] sw, input logic [NP-1:0] hw);
        logic [NP-1:0] r;
        for (int b = 0; b < NP; b++) r[b] = m_fsel[b] ? hw[b] : sw[b];
        return r;
    endfunction

    initial begin
        logic [31:0] rd;
        logic        got;
        logic [3:0]  a;
        logic [31:0] w;
        logic [NP-1:0] nw;

        bus_if.req   = 1'b0;
        bus_if.we    = 1'b0;
        bus_if.addr  = '0;
        bus_if.wdata = '0;

        vecs[0]  = '{1'b0, 4'hA,         32'h0,        32'h0,     20'h0,     20'h0};
        vecs[1]  = '{1'b1, ADDR_OE,      32'hF,        32'h0,     20'h0,     20'hF};
        vecs[2]  = '{1'b1, ADDR_OUT,     32'h5,        32'h0,     20'h5,     20'hF};
        vecs[3]  = '{1'b1, ADDR_OUT_SET, 32'h2,        32'h0,     20'h7,     20'hF};
        vecs[4]  = '{1'b1, ADDR_OUT_CLR, 32'h1,        32'h0,     20'h6,     20'hF};
        vecs[5]  = '{1'b0, ADDR_OUT,     32'h0,        32'h6,     20'h6,     20'hF};
        vecs[6]  = '{1'b1, 4'hA,         32'hFFFFFFFF, 32'h6,     20'h6,     20'hF};
        vecs[7]  = '{1'b0, ADDR_OE,      32'h0,        32'hF,     20'h6,     20'hF};
        vecs[8]  = '{1'b0, ADDR_OUT_SET, 32'h0,        32'h0,     20'h6,     20'hF};
        vecs[9]  = '{1'b0, ADDR_OUT_CLR, 32'h0,        32'h0,     20'h6,     20'hF};
        vecs[10] = '{1'b1, ADDR_OUT,     32'hFFFFFFFF, 32'h0,     20'hFFFFF, 20'hF};
        vecs[11] = '{1'b0, ADDR_OUT,     32'h0,        32'hFFFFF, 20'hFFFFF, 20'hF};
        vecs[12] = '{1'b1, ADDR_OUT,     32'h6,        32'hFFFFF, 20'h6,     20'hF};
        vecs[13] = '{1'b0, ADDR_FSEL,    32'h0,        32'h0,     20'h6,     20'hF};

        // Reset with all pads high.
        pad_i = 20'hFFFFF;
        #2 resetn = 1'b0;
        @(negedge clk);
        check("reset pad_oe", 32'(pad_oe), 32'h0);
        check("reset pad_o", 32'(pad_o), 32'h0);
        check("reset irq", 32'(irq), 32'h0);
        check("reset bus_ready", 32'(bus_if.ready), 32'h0);
        check("reset bus_rdata", bus_if.rdata, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (SS + 1) @(posedge clk);
        rd_chk("IN after reset", ADDR_IN, 32'h000FFFFF);
        pad_i = '0;
        repeat (SS + 3) @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            bus_xfer(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd);
            check($sformatf("vec%0d rdata", i), rd, vecs[i].rdata);
            check($sformatf("vec%0d pad_o", i), 32'(pad_o), 32'(vecs[i].po));
            check($sformatf("vec%0d pad_oe", i), 32'(pad_oe), 32'(vecs[i].poe));
        end

        // Peripheral takes pad 8 while OUT[8]=0, OE[8]=0.
        periph_o  = 20'h00100;
        periph_oe = 20'h00100;
        wr(ADDR_FSEL, 32'h100);
        check("fsel pad_o[8]", 32'(pad_o[8]), 32'h1);
        check("fsel pad_oe[8]", 32'(pad_oe[8]), 32'h1);
        check("fsel pad_o", 32'(pad_o), 32'h106);
        wr(ADDR_FSEL, 32'h0);
        check("unfsel pad_o[8]", 32'(pad_o[8]), 32'h0);
        check("unfsel pad_oe[8]", 32'(pad_oe[8]), 32'h0);
        periph_o  = '0;
        periph_oe = '0;

        // Rising edge on enabled pad 0, pulse on disabled pad 1.
        wr(ADDR_RISE_EN, 32'h1);
        @(negedge clk);
        pad_i[0] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < int'(SS) + 2 && !got; i++) begin
            @(negedge clk);
            got = irq;
        end
        check("irq after rise", 32'(irq), 32'h1);
        rd_chk("status after rise", ADDR_IRQ_STATUS, 32'h1);
        @(negedge clk);
        pad_i[1] = 1'b1;
        repeat (SS + 1) @(negedge clk);
        pad_i[1] = 1'b0;
        repeat (SS + 3) @(negedge clk);
        rd_chk("status disabled pulse", ADDR_IRQ_STATUS, 32'h1);
        wr(ADDR_IRQ_STATUS, 32'h1);
        @(negedge clk);
        check("irq after w1c", 32'(irq), 32'h0);
        rd_chk("status after w1c", ADDR_IRQ_STATUS, 32'h0);

        // W1C accepted on the same edge that records a new rise.
        pad_i[0] = 1'b0;
        repeat (SS + 3) @(negedge clk);
        pad_i[0] = 1'b1;
        repeat (SS + 3) @(negedge clk);
        check("irq before collide", 32'(irq), 32'h1);
        pad_i[0] = 1'b0;
        repeat (SS + 3) @(negedge clk);
        pad_i[0] = 1'b1;
        repeat (SS) @(negedge clk);
        bus_if.req   = 1'b1;
        bus_if.we    = 1'b1;
        bus_if.addr  = ADDR_IRQ_STATUS;
        bus_if.wdata = 32'h1;
        @(negedge clk);
        check("collide bus_ready", 32'(bus_if.ready), 32'h1);
        bus_if.req = 1'b0;
        check("collide irq", 32'(irq), 32'h1);
        @(negedge clk);
        check("collide irq next", 32'(irq), 32'h1);
        rd_chk("collide status", ADDR_IRQ_STATUS, 32'h1);
        wr(ADDR_IRQ_STATUS, 32'h1);
        wr(ADDR_RISE_EN, 32'h0);

        // Held request: ready every second cycle.
        @(negedge clk);
        bus_if.req  = 1'b1;
        bus_if.we   = 1'b0;
        bus_if.addr = 4'hA;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("held ready c%0d", i), 32'(bus_if.ready), (i % 2 == 0) ? 32'h1 : 32'h0);
        end
        bus_if.req = 1'b0;

        // Reset while a write is in ACK.
        @(negedge clk);
        bus_if.req   = 1'b1;
        bus_if.we    = 1'b1;
        bus_if.addr  = ADDR_OUT;
        bus_if.wdata = 32'hABCDE;
        @(negedge clk);
        check("abort bus_ready before", 32'(bus_if.ready), 32'h1);
        resetn = 1'b0;
        #1;
        check("abort bus_ready", 32'(bus_if.ready), 32'h0);
        check("abort pad_o", 32'(pad_o), 32'h0);
        check("abort pad_oe", 32'(pad_oe), 32'h0);
        bus_if.req = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (SS + 3) @(negedge clk);
        rd_chk("abort OUT", ADDR_OUT, 32'h0);
        rd_chk("abort OE", ADDR_OE, 32'h0);

        // Randomized traffic against the register-level model.
        m_out = '0; m_oe = '0; m_fsel = '0; m_ren = '0; m_fen = '0; m_st = '0;
        m_pad = pad_i;
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    a = 4'($urandom_range(0, 15));
                    w = $urandom;
                    nw = w[NP-1:0];
                    if (a == ADDR_OUT)             m_out = nw;
                    else if (a == ADDR_OE)         m_oe = nw;
                    else if (a == ADDR_FSEL)       m_fsel = nw;
                    else if (a == ADDR_RISE_EN)    m_ren = nw;
                    else if (a == ADDR_FALL_EN)    m_fen = nw;
                    else if (a == ADDR_IRQ_STATUS) m_st = m_st & ~nw;
                    else if (a == ADDR_OUT_SET)    m_out = m_out | nw;
                    else if (a == ADDR_OUT_CLR)    m_out = m_out & ~nw;
                    wr(a, w);
                    check($sformatf("rnd%0d wr pad_o", it), 32'(pad_o), 32'(m_pick(m_out, periph_o)));
                    check($sformatf("rnd%0d wr pad_oe", it), 32'(pad_oe), 32'(m_pick(m_oe, periph_oe)));
                end
                1: begin
                    a = 4'($urandom_range(0, 15));
                    rd_chk($sformatf("rnd%0d rd 0x%0h", it, a), a, m_read(a));
                end
                2: begin
                    nw = NP'($urandom);
                    m_st = m_st | (nw & ~m_pad & m_ren) | (~nw & m_pad & m_fen);
                    m_pad = nw;
                    @(negedge clk);
                    pad_i = nw;
                    repeat (SS + 3) @(negedge clk);
                    check($sformatf("rnd%0d irq", it), 32'(irq), (m_st != '0) ? 32'h1 : 32'h0);
                    check($sformatf("rnd%0d periph_i", it), 32'(periph_i), 32'(m_pad));
                end
                default: begin
                    @(negedge clk);
                    periph_o  = NP'($urandom);
                    periph_oe = NP'($urandom);
                    #1;
                    check($sformatf("rnd%0d mux pad_o", it), 32'(pad_o), 32'(m_pick(m_out, periph_o)));
                    check($sformatf("rnd%0d mux pad_oe", it), 32'(pad_oe), 32'(m_pick(m_oe, periph_oe)));
                end
            endcase
        end
        rd_chk("final status", ADDR_IRQ_STATUS, m_read(ADDR_IRQ_STATUS));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
